// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   mdu_op_t  : operation encodings as presented on the op port (op[0]=1 -> unsigned)
//   state_t   : sequencer states
//   mdu_cnt_w : width of the iteration counter, wide enough to hold WIDTH itself
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic int mdu_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Configuration macro: MDU_DIV_EN (when undefined, no divider path is built).
// Ports:
//   is_div  in   1      select trial-subtract (divide) instead of add/shift (only with MDU_DIV_EN)
//   hi      in   WIDTH  upper accumulator (partial product / partial remainder)
//   lo      in   WIDTH  lower accumulator (multiplier bits / dividend bits + quotient)
//   opnd    in   WIDTH  multiplicand or divisor magnitude
//   hi_nxt  out  WIDTH  upper accumulator after this iteration
//   lo_nxt  out  WIDTH  lower accumulator after this iteration
module mdu_step #(
    parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]   shl;
    logic [WIDTH+1:0] diff;
`endif

    always_comb begin
        // Shift-add: conditionally add multiplicand, then shift {carry,hi,lo} right one.
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        // Restoring divide: shift next dividend bit into remainder, trial-subtract.
        // The extra top bit of diff is the borrow; no borrow means quotient bit 1.
        shl  = {hi, lo[WIDTH-1]};
        diff = {1'b0, shl} - {2'b00, opnd};
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shl[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Configuration macro: MDU_DIV_EN. When undefined, DIV/DIVU are accepted but answered
// by a done+ill pulse on the following cycle with hi/lo untouched.
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, accepted only in IDLE
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   WIDTH  operand A (rs / dividend), latched at accept
//   b      in   WIDTH  operand B (rt / divisor), latched at accept
//   busy   out  1      high while an operation is iterating
//   done   out  1      one-cycle pulse, hi/lo valid from this cycle
//   dz     out  1      divide-by-zero flag of the last operation
//   ill    out  1      one-cycle pulse with done for an unsupported op
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             ill,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = mdu_cnt_w(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic               neg_res;
`ifdef MDU_DIV_EN
    logic               is_div, neg_rem, div_zero;
    logic [WIDTH-1:0]   q_fix, r_fix;
`else
    logic               ill_pend;
`endif

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               op_signed, op_div, a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
        a_neg     = op_signed && a[WIDTH-1];
        b_neg     = op_signed && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
`ifdef MDU_DIV_EN
        q_fix     = neg_res ? -acc_lo : acc_lo;
        r_fix     = neg_rem ? -acc_hi : acc_hi;
`endif
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
        .is_div (is_div),
`endif
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`else
            ill_pend <= 1'b0;
`endif
            busy <= 1'b0;
            done <= 1'b0;
            dz   <= 1'b0;
            ill  <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= 1'b0;
            ill  <= 1'b0;
            // busy trails the state by one edge so it covers exactly the WIDTH iteration edges.
            busy <= (state == S_RUN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dz      <= 1'b0;
                        acc_hi  <= '0;
                        acc_lo  <= a_mag;
                        opnd    <= b_mag;
                        cnt     <= CW'(WIDTH);
                        neg_res <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        is_div   <= op_div;
                        neg_rem  <= a_neg;
                        div_zero <= op_div && (b == '0);
                        state    <= S_RUN;
`else
                        ill_pend <= op_div;
                        state    <= op_div ? S_DONE : S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        // Divide by zero: r_fix restores the original dividend.
                        lo <= div_zero ? '1 : q_fix;
                        hi <= r_fix;
                        dz <= div_zero;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
`else
                    if (ill_pend) begin
                        ill <= 1'b1;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, dz, ill;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    int lat;
    int bcnt;
    int ndone;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ill   (ill),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operands to prove they were latched.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h1234_5678;
        b     = 32'h0000_0003;
    endtask

    // Counts edges until done (bounded) and busy samples seen before it.
    task automatic wait_done(output int l, output int bc);
        bit got;
        got = 1'b0;
        l   = 0;
        bc  = 0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                l   = i;
            end else if (busy) begin
                bc++;
            end
        end
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dz",   {63'd0, dz},   64'd0);
        chk("reset_ill",  {63'd0, ill},  64'd0);
        chk("reset_hilo", {hi, lo},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULTU 7*6
        launch(MDU_MULTU, 32'd7, 32'd6);
        wait_done(lat, bcnt);
        chk("multu_lat",  64'(lat),  64'd33);
        chk("multu_busy", 64'(bcnt), 64'd32);
        chk("multu_hilo", {hi, lo},  64'h0000_0000_0000_002A);
        chk("multu_ill",  {63'd0, ill}, 64'd0);

        // MULT -3*5
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bcnt);
        chk("mult_neg_lat",  64'(lat), 64'd33);
        chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // MULTU max*max
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk);
        #1;
        chk("done_pulse_ends", {63'd0, done}, 64'd0);

        // Start during busy is ignored; first result delivered
        launch(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MULTU;
        a     = 32'd100;
        b     = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_start_lat",  64'(lat), 64'd32);
        chk("ign_start_hilo", {hi, lo}, 64'd12);

        // Start in the done cycle is accepted
        launch(MDU_MULT, 32'd2, 32'hFFFF_FFFC);
        wait_done(lat, bcnt);
        chk("b2b_lat",  64'(lat), 64'd33);
        chk("b2b_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF8);
        count_done(40, ndone);
        chk("no_stray_done", 64'(ndone), 64'd0);

        // Reset in cycle 10 of a MULT aborts it
        launch(MDU_MULTU, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo},      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, ndone);
        chk("abort_no_done", 64'(ndone), 64'd0);

        // Load known nonzero hi/lo before the divide cases
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bcnt);
        chk("preload_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

`ifdef MDU_DIV_EN
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        chk("div_neg_lat",  64'(lat), 64'd33);
        chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        launch(MDU_DIVU, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        chk("div_ovf_dz",   {63'd0, dz}, 64'd0);

        launch(MDU_DIVU, 32'd9, 32'd0);
        wait_done(lat, bcnt);
        chk("dz_lat",  64'(lat), 64'd33);
        chk("dz_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
        chk("dz_flag", {63'd0, dz}, 64'd1);
        chk("dz_ill",  {63'd0, ill}, 64'd0);

        launch(MDU_MULTU, 32'd7, 32'd6);
        wait_done(lat, bcnt);
        chk("dz_cleared", {63'd0, dz}, 64'd0);
        chk("after_dz_hilo", {hi, lo}, 64'd42);
`else
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        chk("nodiv_lat",  64'(lat),  64'd1);
        chk("nodiv_busy", 64'(bcnt), 64'd0);
        chk("nodiv_ill",  {63'd0, ill}, 64'd1);
        chk("nodiv_hilo", {hi, lo},  64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk);
        #1;
        chk("nodiv_ill_pulse", {62'd0, ill, done}, 64'd0);

        launch(MDU_DIVU, 32'd9, 32'd0);
        wait_done(lat, bcnt);
        chk("nodiv_dz_lat",  64'(lat), 64'd1);
        chk("nodiv_dz_flag", {63'd0, dz}, 64'd0);
        chk("nodiv_dz_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        launch(MDU_MULTU, 32'd7, 32'd6);
        wait_done(lat, bcnt);
        chk("after_ill_lat",  64'(lat), 64'd33);
        chk("after_ill_hilo", {hi, lo}, 64'd42);
        chk("after_ill_ill",  {63'd0, ill}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
